// File: rtl/pe_code_decoder.sv
// pe_code_decoder: queues 3-bit encoded indices and replays them as timed one-hot strobes
module pe_code_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 2,
    parameter int INVERT_CODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] code_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] dec_out,
    output logic       out_valid,
    output logic       eno
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    cnt, cnt_n, dec_n, head_onehot;
    logic [2:0]    idx;
    logic          push, pop, empty;

    assign in_ready    = count != FULL_COUNT;
    assign empty       = count == '0;
    assign push        = in_valid && in_ready;
    assign idx         = (INVERT_CODE != 0) ? ~mem[rd_ptr] : mem[rd_ptr];
    assign head_onehot = 8'b1 << idx;
    assign out_valid   = |dec_out;
    assign eno         = en || (state == IDLE && empty);

    // Code storage; stale entries are harmless because reset clears the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= code_in;
    end

    // FIFO pointers and occupancy; pushes are accepted regardless of en
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Strobe sequencer: pop in IDLE, hold the line, optional zero gap, en=1 aborts
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dec_n   = dec_out;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!en && !empty) begin
                    pop     = 1'b1;
                    dec_n   = head_onehot;
                    cnt_n   = HOLD_LOAD;
                    state_n = HOLD;
                end else begin
                    dec_n = '0;
                end
            end
            HOLD: begin
                if (en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    dec_n   = '0;
                end else if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else if (GAP_CYCLES > 0) begin
                    dec_n   = '0;
                    cnt_n   = GAP_LOAD;
                    state_n = GAP;
                end else if (!empty) begin
                    pop   = 1'b1;
                    dec_n = head_onehot;
                    cnt_n = HOLD_LOAD;
                end else begin
                    dec_n   = '0;
                    state_n = IDLE;
                end
            end
            GAP: begin
                dec_n = '0;
                if (en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                dec_n   = '0;
            end
        endcase
    end

    // Sequencer state, counter and registered strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dec_out <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dec_out <= dec_n;
        end
    end
endmodule

// File: tb/tb_pe_code_decoder.sv
// tb_pe_code_decoder: directed checks of the default decoder and a back-to-back variant
module tb_pe_code_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, valid_a, ready_a, ov_a, eno_a;
    logic [2:0] code_a;
    logic [7:0] dec_a;
    logic       en_b, valid_b, ready_b, ov_b, eno_b;
    logic [2:0] code_b;
    logic [7:0] dec_b;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pe_code_decoder dut_a (
        .clk(clk), .reset(reset), .en(en_a), .code_in(code_a), .in_valid(valid_a),
        .in_ready(ready_a), .dec_out(dec_a), .out_valid(ov_a), .eno(eno_a)
    );

    pe_code_decoder #(.HOLD_CYCLES(2), .GAP_CYCLES(0), .FIFO_DEPTH(2), .INVERT_CODE(0)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .code_in(code_b), .in_valid(valid_b),
        .in_ready(ready_b), .dec_out(dec_b), .out_valid(ov_b), .eno(eno_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en_a = 1'b1; valid_a = 1'b0; code_a = '0;
        en_b = 1'b1; valid_b = 1'b0; code_b = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst_dec", dec_a, 8'h00);
        chk("rst_ready", {7'd0, ready_a}, 8'h01);
        chk("rst_eno", {7'd0, eno_a}, 8'h01);
        chk("rst_ov", {7'd0, ov_a}, 8'h00);

        // back-to-back: codes 1 and 6, hold 2, no gap, non-inverted
        valid_b = 1'b1; code_b = 3'd1; tick;
        code_b = 3'd6; tick;
        chk("b2b_full", {7'd0, ready_b}, 8'h00);
        valid_b = 1'b0; en_b = 1'b0;
        tick; chk("b2b_0", dec_b, 8'h02);
        tick; chk("b2b_1", dec_b, 8'h02);
        tick; chk("b2b_2", dec_b, 8'h40);
        chk("b2b_ov", {7'd0, ov_b}, 8'h01);
        tick; chk("b2b_3", dec_b, 8'h40);
        tick; chk("b2b_end", dec_b, 8'h00);
        chk("b2b_eno", {7'd0, eno_b}, 8'h01);

        // single code 3'b101 (inverted -> line 2)
        en_a = 1'b0; valid_a = 1'b1; code_a = 3'b101; tick;
        valid_a = 1'b0;
        chk("single_e0_dec", dec_a, 8'h00);
        chk("single_e0_eno", {7'd0, eno_a}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("single_hold%0d", i), dec_a, 8'h04);
        end
        tick; chk("single_gap", dec_a, 8'h00);
        chk("single_gap_eno", {7'd0, eno_a}, 8'h00);
        tick; chk("single_idle_eno", {7'd0, eno_a}, 8'h01);
        chk("single_idle_dec", dec_a, 8'h00);

        // backpressure: third push refused while disabled
        en_a = 1'b1; valid_a = 1'b1; code_a = 3'b111; tick;
        chk("bp_ready1", {7'd0, ready_a}, 8'h01);
        code_a = 3'b000; tick;
        chk("bp_ready2", {7'd0, ready_a}, 8'h00);
        code_a = 3'b011; tick;
        chk("bp_refused", {7'd0, ready_a}, 8'h00);
        chk("bp_dis_dec", dec_a, 8'h00);
        valid_a = 1'b0; en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("bp_first%0d", i), dec_a, 8'h01);
        end
        tick; chk("bp_gap", dec_a, 8'h00);
        tick; chk("bp_idle", dec_a, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("bp_second%0d", i), dec_a, 8'h80);
        end
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("bp_none%0d", i), dec_a, 8'h00);
        end
        chk("bp_eno", {7'd0, eno_a}, 8'h01);

        // abort on 2nd cycle of the 8'h04 strobe, 8'h02 queued behind it
        en_a = 1'b1; valid_a = 1'b1; code_a = 3'b101; tick;
        code_a = 3'b110; tick;
        valid_a = 1'b0; en_a = 1'b0;
        tick; chk("abort_start", dec_a, 8'h04);
        en_a = 1'b1;
        tick; chk("abort_cut", dec_a, 8'h00);
        tick; chk("abort_dis", dec_a, 8'h00);
        chk("abort_eno", {7'd0, eno_a}, 8'h01);
        en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("abort_next%0d", i), dec_a, 8'h02);
        end
        for (int i = 0; i < 5; i++) begin
            tick; chk($sformatf("abort_norepeat%0d", i), dec_a, 8'h00);
        end

        // simultaneous push/pop at count=1
        en_a = 1'b1; valid_a = 1'b1; code_a = 3'b111; tick;
        en_a = 1'b0; code_a = 3'b000; tick;
        valid_a = 1'b0;
        chk("sim_ready", {7'd0, ready_a}, 8'h01);
        chk("sim_first", dec_a, 8'h01);
        for (int i = 0; i < 3; i++) tick;
        chk("sim_first_end", dec_a, 8'h01);
        tick; chk("sim_gap", dec_a, 8'h00);
        tick; chk("sim_idle", dec_a, 8'h00);
        tick; chk("sim_second", dec_a, 8'h80);
        for (int i = 0; i < 6; i++) tick;
        chk("sim_drained_eno", {7'd0, eno_a}, 8'h01);

        // reset mid-hold with two codes queued
        en_a = 1'b1; valid_a = 1'b1; code_a = 3'b111; tick;
        code_a = 3'b000; tick;
        en_a = 1'b0; code_a = 3'b011; tick;
        chk("rst2_hold", dec_a, 8'h01);
        tick;
        valid_a = 1'b0;
        chk("rst2_full", {7'd0, ready_a}, 8'h00);
        reset = 1'b1; tick; tick;
        reset = 1'b0;
        chk("rst2_dec", dec_a, 8'h00);
        chk("rst2_ready", {7'd0, ready_a}, 8'h01);
        chk("rst2_eno", {7'd0, eno_a}, 8'h01);
        for (int i = 0; i < 6; i++) begin
            tick; chk($sformatf("rst2_quiet%0d", i), dec_a, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
